cla_nibble_serial_seq: RTL and testbench

- Multi-cycle sequencer that computes one WIDTH-bit addition by reusing a single 4-bit CLA slice, one nibble per clock.
- The carry is held in a register between nibbles.
- Sits between the approximate-adder datapath experiments and the multiplier's partial-product accumulator. It trades latency for area and accepts operands through a valid/ready handshake.

---
 rtl/cla_nibble_serial_seq_pkg.sv | 26 ++
 rtl/cla_nibble_serial_seq_if.sv | 28 ++
 rtl/cla_nibble_serial_seq_cla.sv | 31 +++
 rtl/cla_nibble_serial_seq.sv | 119 +++++++++++
 tb/tb_cla_nibble_serial_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cla_nibble_serial_seq_pkg.sv
// Shared definitions for the nibble-serial CLA sequencer: FSM encoding,
// slice width and a constant-function clog2.
`default_nettype none

package cla_nibble_serial_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int c_NIB_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_nibble_serial_seq_if.sv
// Operand/result handshake bundle for cla_nibble_serial_seq.
`default_nettype none

interface cla_nibble_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH:0]   SUM;
  logic             BUSY;

  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/cla_nibble_serial_seq_cla.sv
// four_bit_CLA: 4-bit carry-lookahead adder slice, SUM[4] is the carry-out.
`default_nettype none

module four_bit_CLA (
  input  wire logic [3:0] A,
  input  wire logic [3:0] B,
  input  wire logic       C0,
  output logic      [4:0] SUM
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = C0;
  assign w_c[1] = w_g[0] | (w_p[0] & C0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & C0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & C0);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & C0);

  assign SUM = {w_c[4], w_p ^ w_c[3:0]};

endmodule

`default_nettype wire

// File: rtl/cla_nibble_serial_seq.sv
// cla_nibble_serial_seq: WIDTH-bit add through one shared 4-bit CLA, one nibble per clock.
// Optional macro APPROX_LOWER_EN cuts the carry chain below nibble APPROX_NIBS.
`default_nettype none

module cla_nibble_serial_seq
  import cla_nibble_serial_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_NIBS = 1
) (
  input  wire logic         CLK,
  input  wire logic         RST_N,
  cla_nibble_serial_seq_if.slave bus
);

  localparam int c_NIB  = WIDTH / c_NIB_W;
  localparam int c_IDXW = clog2(c_NIB);
  localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NIB - 1);

  if ((WIDTH % c_NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_nibble_serial_seq: WIDTH must be a multiple of 4 and >= 8");
  end
  if (APPROX_NIBS < 1 || APPROX_NIBS > c_NIB - 1) begin : g_bad_approx
    $error("cla_nibble_serial_seq: APPROX_NIBS out of range 1..WIDTH/4-1");
  end

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [c_IDXW-1:0]   r_idx;
  logic [WIDTH:0]      r_sum;

  logic [3:0]          w_sa;
  logic [3:0]          w_sb;
  logic                w_c0;
  logic [4:0]          w_slice;
  logic                w_last;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;

  assign w_sa   = r_a[c_NIB_W*r_idx +: c_NIB_W];
  assign w_sb   = r_b[c_NIB_W*r_idx +: c_NIB_W];
  assign w_last = (r_idx == c_LAST_IDX);

`ifdef APPROX_LOWER_EN
  localparam logic [c_IDXW-1:0] c_APPROX_IDX = c_IDXW'(APPROX_NIBS);
  // Approximate nibbles and the first exact one all see a zero carry-in.
  assign w_c0 = (r_idx <= c_APPROX_IDX) ? 1'b0 : r_carry;
`else
  assign w_c0 = r_carry;
`endif

  four_bit_CLA u_slice (
    .A   (w_sa),
    .B   (w_sb),
    .C0  (w_c0),
    .SUM (w_slice)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.IN_VALID)  w_next = S_RUN;
      S_RUN:   if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.OUT_READY) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == S_IDLE);
    w_out_valid = (r_state == S_DONE);
    w_busy      = (r_state == S_RUN) || (r_state == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.IN_VALID) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.CIN;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[c_NIB_W*r_idx +: c_NIB_W] <= w_slice[3:0];
          r_carry <= w_slice[4];
          r_idx   <= r_idx + 1'b1;
          if (w_last) r_sum[WIDTH] <= w_slice[4];
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign bus.BUSY      = w_busy;
  assign bus.SUM       = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_serial_seq.sv
// Directed self-checking bench for cla_nibble_serial_seq (WIDTH=16).
`default_nettype none

module tb_cla_nibble_serial_seq;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_errors;

  cla_nibble_serial_seq_if #(.WIDTH(16)) u_if ();

  cla_nibble_serial_seq #(.WIDTH(16), .APPROX_NIBS(1)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic start_txn(input logic [15:0] a, input logic [15:0] b, input logic cin);
    chk("accept_ready", {16'd0, u_if.IN_READY}, 17'd1);
    u_if.IN_VALID = 1'b1;
    u_if.A = a;
    u_if.B = b;
    u_if.CIN = cin;
    @(posedge CLK);
    @(negedge CLK);
    u_if.IN_VALID = 1'b0;
    u_if.A = ~a;
    u_if.B = ~b;
    u_if.CIN = ~cin;
  endtask

  task automatic wait_done(input string tag, input logic [16:0] exp);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      chk({tag, "_busy"}, {16'd0, u_if.BUSY}, 17'd1);
      if (u_if.OUT_VALID) break;
    end
    chk({tag, "_latency"}, 17'(lat), 17'd4);
    chk({tag, "_sum"}, u_if.SUM, exp);
  endtask

  task automatic consume(input string tag);
    u_if.OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    u_if.OUT_READY = 1'b0;
    chk({tag, "_idle_ready"}, {16'd0, u_if.IN_READY}, 17'd1);
    chk({tag, "_idle_ovalid"}, {16'd0, u_if.OUT_VALID}, 17'd0);
  endtask

  initial begin
    int first;
    int second;
    n_checks = 0;
    n_errors = 0;
    RST_N = 1'b0;
    u_if.IN_VALID = 1'b0;
    u_if.A = '0;
    u_if.B = '0;
    u_if.CIN = 1'b0;
    u_if.OUT_READY = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {16'd0, u_if.IN_READY}, 17'd1);
    chk("rst_out_valid", {16'd0, u_if.OUT_VALID}, 17'd0);
    chk("rst_busy", {16'd0, u_if.BUSY}, 17'd0);
    chk("rst_sum", u_if.SUM, 17'h00000);
    RST_N = 1'b1;
    @(negedge CLK);

    // Basic add
    start_txn(16'hABCD, 16'h1234, 1'b0);
    wait_done("basic", 17'h0BE01);
    consume("basic");

    // Full carry ripple
    start_txn(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ripple1", 17'h10000);
    consume("ripple1");
    start_txn(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("ripple2", 17'h1FFFF);
    consume("ripple2");

    // Backpressure with new operands pending; OUT_READY high early must be ignored
    u_if.OUT_READY = 1'b1;
    start_txn(16'h1111, 16'h2222, 1'b0);
    u_if.OUT_READY = 1'b0;
    wait_done("bp", 17'h03333);
    u_if.IN_VALID = 1'b1;
    u_if.A = 16'h0005;
    u_if.B = 16'h0006;
    u_if.CIN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("bp_hold_sum", u_if.SUM, 17'h03333);
      chk("bp_hold_ovalid", {16'd0, u_if.OUT_VALID}, 17'd1);
      chk("bp_hold_iready", {16'd0, u_if.IN_READY}, 17'd0);
    end
    u_if.OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    u_if.OUT_READY = 1'b0;
    chk("bp_release_iready", {16'd0, u_if.IN_READY}, 17'd1);
    chk("bp_release_busy", {16'd0, u_if.BUSY}, 17'd0);
    start_txn(16'h0005, 16'h0006, 1'b0);
    wait_done("bp_next", 17'h0000B);
    consume("bp_next");

    // Reset in RUN at idx=2
    start_txn(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midrst_in_ready", {16'd0, u_if.IN_READY}, 17'd1);
    chk("midrst_out_valid", {16'd0, u_if.OUT_VALID}, 17'd0);
    chk("midrst_busy", {16'd0, u_if.BUSY}, 17'd0);
    chk("midrst_sum", u_if.SUM, 17'h00000);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("postrst_busy", {16'd0, u_if.BUSY}, 17'd0);
    start_txn(16'h0001, 16'h0001, 1'b0);
    wait_done("postrst", 17'h00002);
    consume("postrst");

    // Approximate-mode vector
    start_txn(16'h000F, 16'h0001, 1'b1);
`ifdef APPROX_LOWER_EN
    wait_done("approx", 17'h00000);
`else
    wait_done("approx", 17'h00011);
`endif
    consume("approx");

    // Back-to-back with IN_VALID and OUT_READY held high
    first = -1;
    second = -1;
    u_if.A = 16'h1234;
    u_if.B = 16'h4321;
    u_if.CIN = 1'b0;
    u_if.IN_VALID = 1'b1;
    u_if.OUT_READY = 1'b1;
    for (int cyc = 1; cyc <= 30 && second < 0; cyc++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (cyc == 1) begin
        u_if.A = 16'h8000;
        u_if.B = 16'h8000;
        u_if.CIN = 1'b1;
      end
      if (cyc == 7) u_if.IN_VALID = 1'b0;
      if (first > 0 && cyc == first + 1)
        chk("b2b_iready_after_hs", {16'd0, u_if.IN_READY}, 17'd1);
      if (u_if.OUT_VALID) begin
        if (first < 0) begin
          first = cyc;
          chk("b2b_sum1", u_if.SUM, 17'h05555);
        end else begin
          second = cyc;
          chk("b2b_sum2", u_if.SUM, 17'h10001);
        end
      end
    end
    chk("b2b_first_latency", 17'(first), 17'd5);
    chk("b2b_gap", 17'(second - first), 17'd6);
    @(negedge CLK);
    u_if.OUT_READY = 1'b0;
    u_if.IN_VALID = 1'b0;
    @(negedge CLK);
    chk("final_idle", {16'd0, u_if.IN_READY}, 17'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
